// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the SDRAM slot arbiter and its slot timing helper.
// Combinational definitions only; no latency, no flow control.
package sdram_arbiter_pkg;

  localparam int         ADDR_W     = 25;
  localparam int         DATA_W     = 8;
  localparam logic [2:0] PHASE_LAST = 3'd7;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE_SLOT = 2'd0,
    LD_SLOT   = 2'd1,
    CPU_SLOT  = 2'd2,
    VID_SLOT  = 2'd3
  } slot_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester ports plus the SDRAM controller port seen by the arbiter.
// No latency of its own; req is held until the matching one-clock ack.
interface sdram_arbiter_if;
  import sdram_arbiter_pkg::*;

  logic  ld_req;
  logic  ld_we;
  addr_t ld_addr;
  data_t ld_din;
  logic  ld_ack;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_din;
  data_t cpu_dout;
  logic  cpu_ack;

  logic  vid_req;
  addr_t vid_addr;
  data_t vid_dout;
  logic  vid_ack;

  addr_t mem_addr;
  data_t mem_din;
  logic  mem_oe;
  logic  mem_we;
  data_t mem_dout;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_din,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  vid_req, vid_addr,
    input  mem_dout,
    output ld_ack, cpu_dout, cpu_ack, vid_dout, vid_ack,
    output mem_addr, mem_din, mem_oe, mem_we
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_din,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output vid_req, vid_addr,
    output mem_dout,
    input  ld_ack, cpu_dout, cpu_ack, vid_dout, vid_ack,
    input  mem_addr, mem_din, mem_oe, mem_we
  );

endinterface

// File: rtl/sdram_arbiter_slot_phase.sv
// Slot phase counter: a clkref rising edge zeroes phase on the next clock, else it counts 0..7.
// One clock from clkref edge to phase 0; no flow control.
module slot_phase (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkref_i,
  output logic [2:0] phase_o
);

  logic       clkref_q;
  logic [2:0] phase_q;
  logic [2:0] phase_d;

  // The edge detector is left out of reset so a clkref held high never looks like a fresh edge.
  always_ff @(posedge clk) begin
    clkref_q <= clkref_i;
  end

  always_comb begin
    phase_d = phase_q + 3'd1;
    if (clkref_i && !clkref_q) begin
      phase_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 3'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Grants one loader/CPU/video access per 8-clock slot; controller inputs held for the whole slot.
// Ack 8 clocks after a grant at phase 7; requesters wait with req high, idle slots feed refresh.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int CAPTURE_PHASE = 6,
  parameter int REFRESH_MAX   = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clkref,
  sdram_arbiter_if.slave bus
);

  localparam int                BUSY_W    = $clog2(REFRESH_MAX + 1);
  localparam logic [BUSY_W-1:0] BUSY_MAX  = BUSY_W'(REFRESH_MAX);
  localparam logic [2:0]        CAP_PHASE = 3'(CAPTURE_PHASE);

  logic [2:0]        phase;
  slot_e             state_q, state_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic              last_vid_q, last_vid_d;
  addr_t             mem_addr_q, mem_addr_d;
  data_t             mem_din_q, mem_din_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;
  data_t             cpu_dout_q, cpu_dout_d;
  data_t             vid_dout_q, vid_dout_d;

  slot_phase u_slot_phase (
    .clk      (clk),
    .reset    (reset),
    .clkref_i (clkref),
    .phase_o  (phase)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    last_vid_d = last_vid_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_oe_d   = mem_oe_q;
    mem_we_d   = mem_we_q;
    cpu_dout_d = cpu_dout_q;
    vid_dout_d = vid_dout_q;

    if (phase == PHASE_LAST) begin
      if (busy_q == BUSY_MAX) begin
        state_d = IDLE_SLOT;
      end else if (bus.ld_req) begin
        state_d = LD_SLOT;
      end else if (bus.cpu_req && bus.vid_req) begin
        state_d = last_vid_q ? CPU_SLOT : VID_SLOT;
      end else if (bus.cpu_req) begin
        state_d = CPU_SLOT;
      end else if (bus.vid_req) begin
        state_d = VID_SLOT;
      end else begin
        state_d = IDLE_SLOT;
      end

      case (state_d)
        LD_SLOT: begin
          mem_addr_d = bus.ld_addr;
          mem_din_d  = bus.ld_din;
          mem_we_d   = bus.ld_we;
          mem_oe_d   = ~bus.ld_we;
        end
        CPU_SLOT: begin
          mem_addr_d = bus.cpu_addr;
          mem_din_d  = bus.cpu_din;
          mem_we_d   = bus.cpu_we;
          mem_oe_d   = ~bus.cpu_we;
          last_vid_d = 1'b0;
        end
        VID_SLOT: begin
          mem_addr_d = bus.vid_addr;
          mem_we_d   = 1'b0;
          mem_oe_d   = 1'b1;
          last_vid_d = 1'b1;
        end
        default: begin
          // Address and data are left alone so the controller bus does not toggle during refresh.
          mem_we_d = 1'b0;
          mem_oe_d = 1'b0;
        end
      endcase

      if (state_d == IDLE_SLOT) begin
        busy_d = '0;
      end else if (busy_q != BUSY_MAX) begin
        busy_d = busy_q + BUSY_W'(1);
      end
    end

    if ((phase == CAP_PHASE) && mem_oe_q) begin
      if (state_q == CPU_SLOT) begin
        cpu_dout_d = bus.mem_dout;
      end
      if (state_q == VID_SLOT) begin
        vid_dout_d = bus.mem_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE_SLOT;
      busy_q     <= '0;
      last_vid_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_dout_q <= '0;
      vid_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      last_vid_q <= last_vid_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_oe_q   <= mem_oe_d;
      mem_we_q   <= mem_we_d;
      cpu_dout_q <= cpu_dout_d;
      vid_dout_q <= vid_dout_d;
    end
  end

  // Ack marks the last phase of the served slot, which is also the next grant decision.
  assign bus.ld_ack   = (state_q == LD_SLOT)  && (phase == PHASE_LAST);
  assign bus.cpu_ack  = (state_q == CPU_SLOT) && (phase == PHASE_LAST);
  assign bus.vid_ack  = (state_q == VID_SLOT) && (phase == PHASE_LAST);
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.vid_dout = vid_dout_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_oe   = mem_oe_q;
  assign bus.mem_we   = mem_we_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed requests, expected slots queued, acks checked by a monitor.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clkref;
  logic [2:0] ref_cnt = 3'd0;
  logic [2:0] tb_phase;

  int total = 0;
  int bad = 0;
  int ack_total = 0;
  int slot_cnt = 0;
  int last_ack_slot = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    bit          chk_dout;
    int          gap;
  } exp_t;

  exp_t sb[$];

  sdram_arbiter_if bus();

  sdram_arbiter #(.CAPTURE_PHASE(6), .REFRESH_MAX(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .clkref (clkref),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ref_cnt <= ref_cnt + 3'd1;
  assign clkref   = ref_cnt[2];
  assign tb_phase = ref_cnt - 3'd5;

  function automatic data_t model(input addr_t a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  // Memory model presents read data only at the capture phase.
  assign bus.mem_dout = (tb_phase == 3'd6) ? model(bus.mem_addr) : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no ack within bound (got 0, need 1)", name);
  endtask

  task automatic push(input logic [1:0] port, input logic we, input logic [24:0] a,
                      input logic [7:0] din, input logic [7:0] dout, input bit cd, input int gap);
    exp_t e;
    e.port = port; e.we = we; e.addr = a; e.din = din;
    e.dout = dout; e.chk_dout = cd; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_phase(input logic [2:0] p);
    do @(negedge clk); while (tb_phase != p);
  endtask

  task automatic wait_cpu_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 48 && !seen; i++) begin
      @(negedge clk);
      seen = bus.cpu_ack;
    end
    if (!seen) timeout_fail("cpu_ack_timeout");
  endtask

  task automatic drive_cpu(input logic we, input addr_t a, input data_t d, input bit keep);
    bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_req = 1'b1;
    wait_cpu_ack();
    if (!keep) bus.cpu_req = 1'b0;
  endtask

  task automatic drive_vid(input addr_t a, input bit keep);
    bit seen = 1'b0;
    bus.vid_addr = a; bus.vid_req = 1'b1;
    for (int i = 0; i < 48 && !seen; i++) begin
      @(negedge clk);
      seen = bus.vid_ack;
    end
    if (!seen) timeout_fail("vid_ack_timeout");
    if (!keep) bus.vid_req = 1'b0;
  endtask

  task automatic drive_ld(input logic we, input addr_t a, input data_t d);
    bit seen = 1'b0;
    bus.ld_we = we; bus.ld_addr = a; bus.ld_din = d; bus.ld_req = 1'b1;
    for (int i = 0; i < 48 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ld_ack;
    end
    if (!seen) timeout_fail("ld_ack_timeout");
    bus.ld_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected acks never arrived (need 0)", sb.size());
      sb.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  // Monitor: every ack is matched against the oldest queued slot; ack-less slot ends must be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      int   nack;
      logic [1:0] act_port;
      exp_t e;
      if (tb_phase == 3'd7) slot_cnt++;
      nack = int'(bus.ld_ack) + int'(bus.cpu_ack) + int'(bus.vid_ack);
      act_port = bus.ld_ack ? LD_SLOT : bus.cpu_ack ? CPU_SLOT : bus.vid_ack ? VID_SLOT : IDLE_SLOT;
      if (nack != 0) begin
        ack_total++;
        chk("ack_onehot", nack, 1);
        chk("ack_phase", {29'd0, tb_phase}, 7);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: port %0d acked with nothing expected", act_port);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {30'd0, act_port}, {30'd0, e.port});
          chk("slot_addr", {7'd0, bus.mem_addr}, {7'd0, e.addr});
          chk("slot_we", {31'd0, bus.mem_we}, {31'd0, e.we});
          chk("slot_oe", {31'd0, bus.mem_oe}, {31'd0, ~e.we});
          if (e.we) chk("slot_din", {24'd0, bus.mem_din}, {24'd0, e.din});
          if (e.chk_dout)
            chk("port_dout", {24'd0, (e.port == CPU_SLOT) ? bus.cpu_dout : bus.vid_dout},
                {24'd0, e.dout});
          if (e.gap > 0) chk("slot_gap", slot_cnt - last_ack_slot, e.gap);
        end
        last_ack_slot = slot_cnt;
      end else if (tb_phase == 3'd7) begin
        chk("idle_slot_oe_we", {30'd0, bus.mem_oe, bus.mem_we}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_din = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.vid_req = 0; bus.vid_addr = '0;

    repeat (3) @(negedge clk);
    chk("rst_oe", {31'd0, bus.mem_oe}, 0);
    chk("rst_we", {31'd0, bus.mem_we}, 0);
    chk("rst_addr", {7'd0, bus.mem_addr}, 0);
    chk("rst_din", {24'd0, bus.mem_din}, 0);
    chk("rst_acks", {29'd0, bus.ld_ack, bus.cpu_ack, bus.vid_ack}, 0);
    chk("rst_douts", {16'd0, bus.cpu_dout, bus.vid_dout}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    mon_en = 1'b1;

    // Lone CPU read: controller inputs held for the whole slot, data and ack at phase 7.
    push(CPU_SLOT, 1'b0, 25'h0001234, 8'h00, 8'hA5, 1, 0);
    wait_phase(3'd6);
    bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0001234; bus.cpu_req = 1'b1;
    wait_phase(3'd0);
    for (int p = 0; p < 8; p++) begin
      if (p > 0) @(negedge clk);
      chk("t1_oe", {31'd0, bus.mem_oe}, 1);
      chk("t1_addr", {7'd0, bus.mem_addr}, 32'h0001234);
    end
    chk("t1_ack", {31'd0, bus.cpu_ack}, 1);
    chk("t1_dout", {24'd0, bus.cpu_dout}, 32'hA5);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", {31'd0, bus.cpu_ack}, 0);
    chk("t1_idle_after", {31'd0, bus.mem_oe}, 0);
    drain();

    // Lone video read; leaves video as last served.
    push(VID_SLOT, 1'b0, 25'h00ABCDE, 8'h00, 8'hE1, 1, 0);
    drive_vid(25'h00ABCDE, 0);
    drain();

    // Continuous CPU + video: alternate starting with CPU, one forced idle after 7 busy slots.
    push(CPU_SLOT, 0, 25'h0000100, 0, 8'h82, 1, 0);
    push(VID_SLOT, 0, 25'h0002200, 0, 8'hA1, 1, 1);
    push(CPU_SLOT, 0, 25'h0000101, 0, 8'h83, 1, 1);
    push(VID_SLOT, 0, 25'h0002201, 0, 8'hA0, 1, 1);
    push(CPU_SLOT, 0, 25'h0000102, 0, 8'h80, 1, 1);
    push(VID_SLOT, 0, 25'h0002202, 0, 8'hA3, 1, 1);
    push(CPU_SLOT, 0, 25'h0000103, 0, 8'h81, 1, 1);
    push(VID_SLOT, 0, 25'h0002203, 0, 8'hA2, 1, 2);
    push(CPU_SLOT, 0, 25'h0000104, 0, 8'h86, 1, 1);
    push(VID_SLOT, 0, 25'h0002204, 0, 8'hA5, 1, 1);
    fork
      for (int k = 0; k < 5; k++) drive_cpu(1'b0, addr_t'(25'h100 + k), 8'h00, k < 4);
      for (int k = 0; k < 5; k++) drive_vid(addr_t'(25'h2200 + k), k < 4);
    join
    drain();

    // Loader write beats a simultaneous CPU read; CPU follows in the next slot.
    push(LD_SLOT, 1'b1, 25'h0100000, 8'h5A, 8'h00, 0, 0);
    push(CPU_SLOT, 1'b0, 25'h0000300, 8'h00, 8'h80, 1, 1);
    fork
      drive_ld(1'b1, 25'h0100000, 8'h5A);
      drive_cpu(1'b0, 25'h0000300, 8'h00, 0);
    join
    drain();

    // CPU drops req at phase 3 of its granted slot; access still completes.
    push(CPU_SLOT, 1'b0, 25'h0000777, 8'h00, 8'hF3, 1, 0);
    wait_phase(3'd6);
    bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000777; bus.cpu_req = 1'b1;
    wait_phase(3'd0);
    wait_phase(3'd3);
    bus.cpu_req = 1'b0;
    wait_cpu_ack();
    drain();

    // CPU write must leave the previously read data in cpu_dout.
    push(CPU_SLOT, 1'b1, 25'h0000055, 8'h3C, 8'hF3, 1, 0);
    drive_cpu(1'b1, 25'h0000055, 8'h3C, 0);
    drain();

    // Request withdrawn before phase 7 is never granted.
    base = ack_total;
    wait_phase(3'd1);
    bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000888; bus.cpu_req = 1'b1;
    wait_phase(3'd4);
    bus.cpu_req = 1'b0;
    repeat (24) @(negedge clk);
    chk("early_drop_no_ack", ack_total, base);

    // Reset at phase 4 of a write slot: outputs to reset values next clock, ack lost.
    base = ack_total;
    wait_phase(3'd6);
    bus.cpu_we = 1'b1; bus.cpu_addr = 25'h0000600; bus.cpu_din = 8'h99; bus.cpu_req = 1'b1;
    wait_phase(3'd0);
    bus.cpu_req = 1'b0;
    wait_phase(3'd1);
    chk("t5_we_active", {31'd0, bus.mem_we}, 1);
    chk("t5_addr_active", {7'd0, bus.mem_addr}, 32'h0000600);
    chk("t5_din_active", {24'd0, bus.mem_din}, 32'h99);
    wait_phase(3'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_we", {31'd0, bus.mem_we}, 0);
    chk("t5_rst_oe", {31'd0, bus.mem_oe}, 0);
    chk("t5_rst_addr", {7'd0, bus.mem_addr}, 0);
    chk("t5_rst_din", {24'd0, bus.mem_din}, 0);
    chk("t5_rst_douts", {16'd0, bus.cpu_dout, bus.vid_dout}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (24) @(negedge clk);
    chk("t5_ack_lost", ack_total, base);

    // After reset video wins the first contention.
    push(VID_SLOT, 1'b0, 25'h0000020, 8'h00, 8'hA3, 1, 0);
    push(CPU_SLOT, 1'b0, 25'h0000010, 8'h00, 8'h93, 1, 1);
    fork
      drive_cpu(1'b0, 25'h0000010, 8'h00, 0);
      drive_vid(25'h0000020, 0);
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
